// File: rtl/mips_pkg.sv
// Shared types for the ID/EX pipeline stage: control bundle and stall FSM states.
package mips_pkg;

    localparam int unsigned RegAddrW = 5;

    // Control bundle produced by decode; packed MSB-first as listed.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef enum logic [0:0] {
        StRun,
        StLuStall
    } state_t;

endpackage

// File: rtl/lu_hazard_det.sv
// Load-use hazard compare: decode consumer against a load sitting in EX.
module lu_hazard_det
    import mips_pkg::*;
(
    input  logic                run,
    input  logic                dec_valid,
    input  logic                dec_uses_rs,
    input  logic                dec_uses_rt,
    input  logic [RegAddrW-1:0] dec_rs,
    input  logic [RegAddrW-1:0] dec_rt,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic [RegAddrW-1:0] ex_dest,
    output logic                hazard
);

    logic rs_match;
    logic rt_match;

    // Only a real load writing a non-zero register can starve a consumer.
    always_comb begin
        rs_match = dec_uses_rs && (ex_dest == dec_rs);
        rt_match = dec_uses_rt && (ex_dest == dec_rt);
        hazard   = run && dec_valid && ex_valid && ex_mem_read &&
                   (ex_dest != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall control and a saturating stall counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                ip_clk,
    input  logic                ip_rst_n,
    input  logic                ip_DEC_valid,
    input  logic [4:0]          ip_DEC_RS,
    input  logic [4:0]          ip_DEC_RT,
    input  logic [4:0]          ip_DEC_RD,
    input  logic                ip_DEC_uses_rs,
    input  logic                ip_DEC_uses_rt,
    input  ctrl_t               ip_DEC_ctrl,
    input  logic [DATA_W-1:0]   ip_DEC_rs_data,
    input  logic [DATA_W-1:0]   ip_DEC_rt_data,
    input  logic [DATA_W-1:0]   ip_DEC_imm,
    input  logic [DATA_W-1:0]   ip_DEC_pc4,
    input  logic                ip_flush,
    output logic                op_EX_valid,
    output ctrl_t               op_EX_ctrl,
    output logic [4:0]          op_EX_RS,
    output logic [4:0]          op_EX_RT,
    output logic [4:0]          op_EX_dest,
    output logic [DATA_W-1:0]   op_EX_rs_data,
    output logic [DATA_W-1:0]   op_EX_rt_data,
    output logic [DATA_W-1:0]   op_EX_imm,
    output logic [DATA_W-1:0]   op_EX_pc4,
    output logic                op_PC_write,
    output logic                op_IFID_write,
    output logic                op_stall,
    output logic [CNT_W-1:0]    op_stall_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hazard;

    logic               valid_q;
    ctrl_t              ctrl_q;
    logic [4:0]         rs_q, rt_q, dest_q;
    logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q, pc4_q;

    lu_hazard_det u_hazard (
        .run         (state_q == StRun),
        .dec_valid   (ip_DEC_valid),
        .dec_uses_rs (ip_DEC_uses_rs),
        .dec_uses_rt (ip_DEC_uses_rt),
        .dec_rs      (ip_DEC_RS),
        .dec_rt      (ip_DEC_RT),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_dest     (dest_q),
        .hazard      (hazard)
    );

    // Stall decision, fetch enables, FSM next state and counter next value.
    always_comb begin
        op_stall      = hazard && !ip_flush;
        // Enables held low while in reset so fetch does not advance.
        op_PC_write   = ip_rst_n && !op_stall;
        op_IFID_write = ip_rst_n && !op_stall;

        state_d = StRun;
        unique case (state_q)
            StRun:     state_d = op_stall ? StLuStall : StRun;
            StLuStall: state_d = StRun;
            default:   state_d = StRun;
        endcase

        cnt_d = cnt_q;
        if (op_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register: bubble on stall/flush, otherwise capture decode.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (op_stall || ip_flush) begin
                valid_q   <= 1'b0;
                ctrl_q    <= '0;
                rs_q      <= '0;
                rt_q      <= '0;
                dest_q    <= '0;
                rs_data_q <= '0;
                rt_data_q <= '0;
                imm_q     <= '0;
                pc4_q     <= '0;
            end else begin
                valid_q   <= ip_DEC_valid;
                ctrl_q    <= ip_DEC_valid ? ip_DEC_ctrl : ctrl_t'('0);
                rs_q      <= ip_DEC_RS;
                rt_q      <= ip_DEC_RT;
                dest_q    <= ip_DEC_ctrl.reg_dst ? ip_DEC_RD : ip_DEC_RT;
                rs_data_q <= ip_DEC_rs_data;
                rt_data_q <= ip_DEC_rt_data;
                imm_q     <= ip_DEC_imm;
                pc4_q     <= ip_DEC_pc4;
            end
        end
    end

    assign op_EX_valid    = valid_q;
    assign op_EX_ctrl     = ctrl_q;
    assign op_EX_RS       = rs_q;
    assign op_EX_RT       = rt_q;
    assign op_EX_dest     = dest_q;
    assign op_EX_rs_data  = rs_data_q;
    assign op_EX_rt_data  = rt_data_q;
    assign op_EX_imm      = imm_q;
    assign op_EX_pc4      = pc4_q;
    assign op_stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic vs a model.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW     = 32;
    localparam int CW     = 4;
    localparam int CntMax = (1 << CW) - 1;

    localparam ctrl_t CtrlLw   = 9'b110101000;
    localparam ctrl_t CtrlAdd  = 9'b100010010;
    localparam ctrl_t CtrlAddi = 9'b100001000;
    localparam ctrl_t CtrlSw   = 9'b001001000;

    logic ip_clk, ip_rst_n, ip_DEC_valid, ip_DEC_uses_rs, ip_DEC_uses_rt, ip_flush;
    logic [4:0] ip_DEC_RS, ip_DEC_RT, ip_DEC_RD;
    ctrl_t ip_DEC_ctrl;
    logic [DW-1:0] ip_DEC_rs_data, ip_DEC_rt_data, ip_DEC_imm, ip_DEC_pc4;
    logic op_EX_valid, op_PC_write, op_IFID_write, op_stall;
    ctrl_t op_EX_ctrl;
    logic [4:0] op_EX_RS, op_EX_RT, op_EX_dest;
    logic [DW-1:0] op_EX_rs_data, op_EX_rt_data, op_EX_imm, op_EX_pc4;
    logic [CW-1:0] op_stall_count;

    int total = 0;
    int bad   = 0;

    // Reference model of the EX register contents and stall bookkeeping.
    logic          m_valid;
    ctrl_t         m_ctrl;
    logic [4:0]    m_rs, m_rt, m_dest;
    logic [DW-1:0] m_rs_data, m_rt_data, m_imm, m_pc4;
    logic          m_in_stall;
    int            m_cnt;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .ip_clk         (ip_clk),
        .ip_rst_n       (ip_rst_n),
        .ip_DEC_valid   (ip_DEC_valid),
        .ip_DEC_RS      (ip_DEC_RS),
        .ip_DEC_RT      (ip_DEC_RT),
        .ip_DEC_RD      (ip_DEC_RD),
        .ip_DEC_uses_rs (ip_DEC_uses_rs),
        .ip_DEC_uses_rt (ip_DEC_uses_rt),
        .ip_DEC_ctrl    (ip_DEC_ctrl),
        .ip_DEC_rs_data (ip_DEC_rs_data),
        .ip_DEC_rt_data (ip_DEC_rt_data),
        .ip_DEC_imm     (ip_DEC_imm),
        .ip_DEC_pc4     (ip_DEC_pc4),
        .ip_flush       (ip_flush),
        .op_EX_valid    (op_EX_valid),
        .op_EX_ctrl     (op_EX_ctrl),
        .op_EX_RS       (op_EX_RS),
        .op_EX_RT       (op_EX_RT),
        .op_EX_dest     (op_EX_dest),
        .op_EX_rs_data  (op_EX_rs_data),
        .op_EX_rt_data  (op_EX_rt_data),
        .op_EX_imm      (op_EX_imm),
        .op_EX_pc4      (op_EX_pc4),
        .op_PC_write    (op_PC_write),
        .op_IFID_write  (op_IFID_write),
        .op_stall       (op_stall),
        .op_stall_count (op_stall_count)
    );

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    task automatic model_clear();
        m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_dest = '0;
        m_rs_data = '0; m_rt_data = '0; m_imm = '0; m_pc4 = '0;
        m_in_stall = 1'b0;
    endtask

    // A consumer stalls when the previous cycle did not stall, EX holds a load to a
    // non-zero register, and the consumer reads that register; a flush overrides.
    function automatic logic model_stall();
        logic dep;
        dep = (ip_DEC_uses_rs && m_dest == ip_DEC_RS) || (ip_DEC_uses_rt && m_dest == ip_DEC_RT);
        return !m_in_stall && ip_DEC_valid && m_valid && m_ctrl.mem_read && (m_dest != 5'd0)
               && dep && !ip_flush;
    endfunction

    // Advance one clock and update the model; returns at posedge+1.
    task automatic tick();
        logic s;
        s = model_stall();
        @(posedge ip_clk);
        if (s || ip_flush) begin
            model_clear();
        end else begin
            m_valid   = ip_DEC_valid;
            m_ctrl    = ip_DEC_valid ? ip_DEC_ctrl : ctrl_t'('0);
            m_rs      = ip_DEC_RS;
            m_rt      = ip_DEC_RT;
            m_dest    = ip_DEC_ctrl.reg_dst ? ip_DEC_RD : ip_DEC_RT;
            m_rs_data = ip_DEC_rs_data;
            m_rt_data = ip_DEC_rt_data;
            m_imm     = ip_DEC_imm;
            m_pc4     = ip_DEC_pc4;
        end
        m_in_stall = s;
        if (s && m_cnt < CntMax) m_cnt++;
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic urs, input logic urt,
                             input ctrl_t c, input logic fl);
        ip_DEC_valid = v; ip_DEC_RS = rs; ip_DEC_RT = rt; ip_DEC_RD = rd;
        ip_DEC_uses_rs = urs; ip_DEC_uses_rt = urt; ip_DEC_ctrl = c; ip_flush = fl;
        ip_DEC_rs_data = $urandom; ip_DEC_rt_data = $urandom;
        ip_DEC_imm = $urandom; ip_DEC_pc4 = $urandom;
    endtask

    task automatic test_reset();
        ip_rst_n = 1'b0;
        model_clear();
        m_cnt = 0;
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CtrlLw, 1'b0);
        repeat (2) @(posedge ip_clk);
        #1;
        total++; if (op_EX_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %0b want 0", op_EX_valid); end
        total++; if (op_EX_ctrl !== 9'd0) begin bad++; $display("FAIL rst_ctrl got %0h want 0", op_EX_ctrl); end
        total++; if ({op_EX_RS, op_EX_RT, op_EX_dest} !== 15'd0) begin
            bad++; $display("FAIL rst_regs got %0h want 0", {op_EX_RS, op_EX_RT, op_EX_dest}); end
        total++; if ({op_EX_rs_data, op_EX_rt_data, op_EX_imm, op_EX_pc4} !== '0) begin
            bad++; $display("FAIL rst_data got %0h want 0", {op_EX_rs_data, op_EX_rt_data, op_EX_imm, op_EX_pc4}); end
        total++; if (op_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got %0b want 0", op_stall); end
        total++; if ({op_PC_write, op_IFID_write} !== 2'b00) begin
            bad++; $display("FAIL rst_enables got %0b want 00", {op_PC_write, op_IFID_write}); end
        total++; if (op_stall_count !== '0) begin bad++; $display("FAIL rst_count got %0d want 0", op_stall_count); end
        ip_rst_n = 1'b1;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        total++; if ({op_PC_write, op_IFID_write} !== 2'b11) begin
            bad++; $display("FAIL rst_release_enables got %0b want 11", {op_PC_write, op_IFID_write}); end
        tick();
    endtask

    task automatic test_load_use();
        logic [DW-1:0] add_rs_data;
        set_instr(1'b1, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, CtrlLw, 1'b0);
        tick();
        total++; if (op_EX_dest !== 5'd8 || op_EX_ctrl !== CtrlLw) begin
            bad++; $display("FAIL lu_load_in_ex got dest=%0d ctrl=%0h want dest=8 ctrl=%0h", op_EX_dest, op_EX_ctrl, CtrlLw); end
        set_instr(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, CtrlAdd, 1'b0);
        add_rs_data = ip_DEC_rs_data;
        #1;
        total++; if ({op_stall, op_PC_write, op_IFID_write} !== 3'b100) begin
            bad++; $display("FAIL lu_stall got %0b want 100", {op_stall, op_PC_write, op_IFID_write}); end
        tick();
        total++; if (op_EX_valid !== 1'b0 || op_EX_ctrl !== 9'd0 || op_EX_dest !== 5'd0) begin
            bad++; $display("FAIL lu_bubble got v=%0b ctrl=%0h dest=%0d want 0", op_EX_valid, op_EX_ctrl, op_EX_dest); end
        total++; if ({op_stall, op_PC_write, op_IFID_write} !== 3'b011) begin
            bad++; $display("FAIL lu_release got %0b want 011", {op_stall, op_PC_write, op_IFID_write}); end
        total++; if (op_stall_count !== CW'(1)) begin bad++; $display("FAIL lu_count got %0d want 1", op_stall_count); end
        tick();
        total++; if (op_EX_valid !== 1'b1 || op_EX_dest !== 5'd10 || op_EX_rs_data !== add_rs_data) begin
            bad++; $display("FAIL lu_add_in_ex got v=%0b dest=%0d rs=%0h want 1 10 %0h",
                            op_EX_valid, op_EX_dest, op_EX_rs_data, add_rs_data); end
    endtask

    task automatic test_zero_dest();
        set_instr(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, CtrlLw, 1'b0);
        tick();
        set_instr(1'b1, 5'd0, 5'd4, 5'd11, 1'b1, 1'b1, CtrlAdd, 1'b0);
        #1;
        total++; if (op_stall !== 1'b0) begin bad++; $display("FAIL zero_dest_stall got %0b want 0", op_stall); end
        tick();
        total++; if (op_EX_valid !== 1'b1 || op_EX_dest !== 5'd11) begin
            bad++; $display("FAIL zero_dest_capture got v=%0b dest=%0d want 1 11", op_EX_valid, op_EX_dest); end
    endtask

    task automatic test_unused_operand();
        set_instr(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 1'b0, CtrlLw, 1'b0);
        tick();
        set_instr(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 1'b0, CtrlSw, 1'b0);
        #1;
        total++; if ({op_stall, op_PC_write} !== 2'b01) begin
            bad++; $display("FAIL unused_rt_stall got %0b want 01", {op_stall, op_PC_write}); end
        tick();
        total++; if (op_EX_valid !== 1'b1 || op_EX_ctrl !== CtrlSw) begin
            bad++; $display("FAIL unused_rt_capture got v=%0b ctrl=%0h want 1 %0h", op_EX_valid, op_EX_ctrl, CtrlSw); end
    endtask

    task automatic test_flush_priority();
        set_instr(1'b1, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, CtrlLw, 1'b0);
        tick();
        set_instr(1'b1, 5'd8, 5'd8, 5'd12, 1'b1, 1'b1, CtrlAdd, 1'b1);
        #1;
        total++; if ({op_stall, op_PC_write, op_IFID_write} !== 3'b011) begin
            bad++; $display("FAIL flush_prio got %0b want 011", {op_stall, op_PC_write, op_IFID_write}); end
        tick();
        total++; if ({op_EX_valid, op_EX_ctrl, op_EX_dest, op_EX_rs_data} !== '0) begin
            bad++; $display("FAIL flush_bubble got %0h want 0", {op_EX_valid, op_EX_ctrl, op_EX_dest, op_EX_rs_data}); end
        total++; if (op_stall_count !== CW'(1)) begin
            bad++; $display("FAIL flush_count got %0d want 1", op_stall_count); end
    endtask

    task automatic test_dest_select();
        set_instr(1'b1, 5'd1, 5'd7, 5'd5, 1'b1, 1'b1, CtrlAdd, 1'b0);
        tick();
        total++; if (op_EX_dest !== 5'd5) begin bad++; $display("FAIL dest_rd got %0d want 5", op_EX_dest); end
        set_instr(1'b1, 5'd1, 5'd7, 5'd5, 1'b1, 1'b0, CtrlAddi, 1'b0);
        tick();
        total++; if (op_EX_dest !== 5'd7) begin bad++; $display("FAIL dest_rt got %0d want 7", op_EX_dest); end
    endtask

    task automatic test_random();
        logic exp_s;
        for (int i = 0; i < 400; i++) begin
            set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                      ctrl_t'($urandom_range(0, 511)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) ip_DEC_ctrl.mem_read = 1'b1;
            #1;
            exp_s = model_stall();
            total++; if ({op_stall, op_PC_write, op_IFID_write} !== {exp_s, !exp_s, !exp_s}) begin
                bad++; $display("FAIL rand_comb[%0d] got %0b want %0b", i,
                                {op_stall, op_PC_write, op_IFID_write}, {exp_s, !exp_s, !exp_s}); end
            tick();
            total++; if ({op_EX_valid, op_EX_ctrl, op_EX_RS, op_EX_RT, op_EX_dest, op_EX_rs_data,
                          op_EX_rt_data, op_EX_imm, op_EX_pc4} !==
                         {m_valid, m_ctrl, m_rs, m_rt, m_dest, m_rs_data, m_rt_data, m_imm, m_pc4}) begin
                bad++; $display("FAIL rand_ex[%0d] got %0h want %0h", i,
                    {op_EX_valid, op_EX_ctrl, op_EX_RS, op_EX_RT, op_EX_dest, op_EX_rs_data,
                     op_EX_rt_data, op_EX_imm, op_EX_pc4},
                    {m_valid, m_ctrl, m_rs, m_rt, m_dest, m_rs_data, m_rt_data, m_imm, m_pc4}); end
            total++; if (op_stall_count !== CW'(m_cnt)) begin
                bad++; $display("FAIL rand_count[%0d] got %0d want %0d", i, op_stall_count, m_cnt); end
        end
    endtask

    // A self-dependent load chain stalls every other cycle; drive it past saturation.
    task automatic test_saturation();
        int stalls;
        stalls = 0;
        set_instr(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, CtrlLw, 1'b0);
        for (int i = 0; i < 2 * CntMax + 10; i++) begin
            #1;
            if (op_stall === 1'b1) stalls++;
            tick();
        end
        total++; if (stalls < CntMax + 2) begin
            bad++; $display("FAIL sat_stall_count got %0d stalls want >= %0d", stalls, CntMax + 2); end
        total++; if (op_stall_count !== CW'(CntMax) || m_cnt != CntMax) begin
            bad++; $display("FAIL sat_hold got %0d want %0d", op_stall_count, CntMax); end
    endtask

    task automatic test_reset_mid_stall();
        set_instr(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, CtrlLw, 1'b0);
        // Align so a load is in EX and the next edge takes the stall.
        #1;
        if (op_stall !== 1'b1) tick();
        #1;
        total++; if (op_stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got %0b want 1", op_stall); end
        tick();
        total++; if ({op_stall, op_PC_write} !== 2'b01) begin
            bad++; $display("FAIL mid_in_lu_stall got %0b want 01", {op_stall, op_PC_write}); end
        #2;
        ip_rst_n = 1'b0;
        #1;
        total++; if ({op_stall, op_PC_write, op_IFID_write, op_stall_count} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs got %0h want 0",
                            {op_stall, op_PC_write, op_IFID_write, op_stall_count}); end
        total++; if ({op_EX_valid, op_EX_ctrl, op_EX_dest} !== '0) begin
            bad++; $display("FAIL mid_reset_ex got %0h want 0", {op_EX_valid, op_EX_ctrl, op_EX_dest}); end
        @(posedge ip_clk);
        #1;
        ip_rst_n = 1'b1;
        model_clear();
        m_cnt = 0;
        #1;
        total++; if ({op_stall, op_PC_write, op_EX_valid} !== 3'b010) begin
            bad++; $display("FAIL post_reset_first got %0b want 010", {op_stall, op_PC_write, op_EX_valid}); end
        tick();
        total++; if (op_stall !== 1'b1) begin bad++; $display("FAIL post_reset_run got %0b want 1", op_stall); end
        tick();
        total++; if (op_stall_count !== CW'(1)) begin
            bad++; $display("FAIL post_reset_count got %0d want 1", op_stall_count); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_dest();
        test_unused_operand();
        test_flush_priority();
        test_dest_select();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 ip_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 ip_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ip_DEC_valid  in  1  decode stage holds a real instruction.
REQ-006 ip_DEC_RS / ip_DEC_RT / ip_DEC_RD  in  5 each  decoded register specifiers.
REQ-007 ip_DEC_uses_rs / ip_DEC_uses_rt  in  1 each  instruction actually reads that operand.
REQ-008 ip_DEC_ctrl  in  ctrl_t (9)  control bundle {RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, Branch, ALUOp[1:0]}.
REQ-009 ip_DEC_rs_data / ip_DEC_rt_data / ip_DEC_imm / ip_DEC_pc4  in  DATA_W each  operands, sign-extended immediate, PC+4.
REQ-010 ip_flush  in  1  taken branch/jump resolved in EX; squash decode instruction.
REQ-011 op_EX_valid, op_EX_ctrl (ctrl_t), op_EX_RS, op_EX_RT, op_EX_dest (5), op_EX_rs_data, op_EX_rt_data, op_EX_imm, op_EX_pc4  out  registered ID/EX contents; op_EX_RS/op_EX_RT feed forwarding-unit Rs/Rt compares.
REQ-012 op_PC_write / op_IFID_write  out  1 each  enables for PC and IF/ID registers.
REQ-013 op_stall  out  1  load-use stall in progress this cycle.
REQ-014 op_stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-015 Hazard (combinational) SHALL be: state RUN & ip_DEC_valid & op_EX_valid & op_EX_ctrl.MemRead & op_EX_dest!=0 & ((ip_DEC_uses_rs & op_EX_dest==ip_DEC_RS) | (ip_DEC_uses_rt & op_EX_dest==ip_DEC_RT)).
REQ-016 op_stall SHALL equal hazard & ~ip_flush; op_PC_write = op_IFID_write = ~op_stall.
REQ-017 FSM states RUN, LU_STALL; RUN->LU_STALL on op_stall; LU_STALL->RUN unconditionally after exactly one cycle; hazard never asserted in LU_STALL.
REQ-018 On op_stall or ip_flush, next edge SHALL load a bubble: op_EX_valid=0, op_EX_ctrl=0, all other EX fields 0.
REQ-019 Otherwise next edge SHALL capture decode inputs; op_EX_valid = ip_DEC_valid; ctrl forced to 0 when ip_DEC_valid=0.
REQ-020 op_EX_dest SHALL capture ip_DEC_ctrl.RegDst ? ip_DEC_RD : ip_DEC_RT.
REQ-021 ip_flush SHALL take priority over hazard: bubble loaded, op_stall=0, PC/IFID enables =1, FSM to RUN.
REQ-022 Load-to-use latency SHALL be exactly one bubble; dependent instruction enters EX with the load in MEM/WB so forwarding select 01 applies.
REQ-023 Loads to $0 or consumers not using the matching operand SHALL cause no stall.
REQ-024 op_stall_count SHALL increment by 1 on each cycle with op_stall=1 and hold at all-ones (no wrap).

Reset
REQ-025 While ip_rst_n=0: all op_EX_* =0, FSM=RUN, op_stall_count=0, op_stall=0, op_PC_write=op_IFID_write=0.
REQ-026 Reset assertion mid-stall SHALL abort the stall immediately; first cycle after deassertion is RUN with EX empty.

Structure
REQ-027 ctrl_t packed struct and FSM state enum SHALL live in shared package mips_pkg.
REQ-028 Hazard compare SHALL be one combinational sub-module lu_hazard_det; registers and FSM in id_ex_stage.

Verification
REQ-029 lw $8 in EX (MemRead, dest 8), decode add uses rs=8 -> op_stall=1, PC/IFID write=0 one cycle, next EX bubble, then add in EX, op_stall_count=1.
REQ-030 lw $0 in EX, decode rs=0 -> no stall, add captured next edge.
REQ-031 lw dest 9 in EX, decode sw uses_rt=0, rt=9 -> no stall.
REQ-032 Hazard and ip_flush same cycle -> op_stall=0, bubble loaded, enables=1, counter unchanged.
REQ-033 RegDst=1, RD=5, RT=7 -> op_EX_dest=5; RegDst=0 -> op_EX_dest=7.
REQ-034 Counter preloaded near 0xFFFF via repeated stalls -> holds 0xFFFF; ip_rst_n low during LU_STALL -> all outputs 0 immediately.
